mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Iterative controller and datapath for the RV32M multiply/divide instructions. It sits beside the main ALU in the EX stage. It accepts one M-extension operation at a time from the control unit/decoder and runs a 32-step shift-add multiply or restoring divide. While it runs it holds the pipeline with a stall signal, then presents a one-cycle result. Divide-by-zero and signed-overflow cases finish on a fast path per the RISC-V specification.

## Interface
- XLEN, 32, operand/result width. Only 32 is supported.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe. Sampled only in IDLE or DONE.
- funct3  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  32  operand A (multiplicand/dividend).
- rs2_data  in  32  operand B (multiplier/divisor).
- flush  in  1  abort the current operation (branch mispredict/trap).
- stall  out  1  hold IF/ID/EX pipeline registers.
- busy  out  1  high in BUSY state.
- result_valid  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  final result. Holds its value until the next completion.

## Operation
- States are IDLE, BUSY and DONE.
- Transitions:
  - IDLE→BUSY on start when no special case applies.
  - IDLE→DONE on start when a special case applies.
  - BUSY→DONE when step counter = 31.
  - DONE→IDLE when start=0.
  - DONE→BUSY or DONE on start (back-to-back accept).
- Operands, funct3 and sign flags are latched on the accepting edge. Later changes to the inputs have no effect.
- Signed ops convert operands to magnitudes at accept and record the result sign:
  - MUL/MULH: sign = a[31]^b[31].
  - MULHSU: only rs1 is signed.
  - DIV: sign = a[31]^b[31].
  - REM: sign = a[31].
- Multiply: 64-bit accumulator, one shift-add per cycle for 32 cycles.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return the sign-corrected product[63:32].
  - The sign correction is a 64-bit two's-complement negate.
- Divide: restoring, one quotient bit per cycle for 32 cycles on magnitudes. The sign is corrected in DONE.
- Special cases resolve at accept and do not use the iterative path:
  - divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Step counter is 5 bits. It clears on accept and increments each BUSY cycle; it does not wrap beyond 31.
- stall = (state==BUSY) | (start & (state==IDLE | state==DONE)). This holds the issuing instruction in EX until DONE.
- busy = (state==BUSY).
- result_valid = (state==DONE), for exactly one cycle per accepted operation.
- flush from any state returns to IDLE on the next edge:
  - result_valid is not asserted for the aborted operation.
  - result is left unchanged.
  - flush has priority over start in the same cycle, so start is ignored.
- start in BUSY is ignored and does not queue.
- Reset mid-operation returns to IDLE immediately. The operation is lost.

## Timing
- Reset values: state=IDLE, stall=0, busy=0, result_valid=0, result=0, counter=0.
- Normal latency:
  - start sampled at edge E0.
  - BUSY for edges E1..E32.
  - result_valid high in the cycle after E32, i.e. 33 cycles after E0.
- Special-case latency: result_valid is high in the cycle after E0 (1 cycle).
- stall is high from the start cycle through the last BUSY cycle. It is low in the DONE cycle, so the pipeline advances as the result is consumed.
- Back-to-back: start in the DONE cycle is accepted at that edge, with no IDLE bubble.
- Outputs are registered except stall, which is combinational from start and state.

## Test plan
- MUL 7 × 6 → result_valid 33 cycles after accept, result = 42; stall high for 33 cycles, then low.
- MULH 0xFFFFFFFF × 0xFFFFFFFF (i.e. −1 × −1) → 0x00000000; MULHU on the same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 % 2 → 0xFFFFFFFF (−1); DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
- Special cases, each with result_valid one cycle after accept:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Flush at BUSY cycle 10 → IDLE next cycle; no result_valid; result keeps its previous value; a new start then completes normally.
- Two back-to-back operations with start held in the DONE cycle → second result_valid exactly 33 cycles after the first; reset asserted mid-BUSY → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with fast-path divide-by-zero and overflow results.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        cnt;
    logic              accept;

    // Operation context captured at accept; the datapath itself is not reset.
    logic [2:0]        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   opb_r;
    logic [2*XLEN-1:0] acc_r;

    logic              in_div;
    logic              in_rem;
    logic              in_a_signed;
    logic              in_b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              in_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] acc_step;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Applies the recorded sign and selects the architectural result half.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic neg,
                                                 input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? (~acc + 1'b1) : acc;
        quo  = magnitude(acc[XLEN-1:0], neg);
        rem  = magnitude(acc[2*XLEN-1:XLEN], neg);
        case (op)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quo;
            default:                return rem;
        endcase
    endfunction

    // Decode of the incoming request, used only on the accepting edge.
    always_comb begin
        in_div      = funct3[2];
        in_rem      = funct3[2] & funct3[1];
        in_a_signed = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        in_b_signed = in_div ? ~funct3[0] : ~funct3[1];
        a_neg       = in_a_signed & rs1_data[XLEN-1];
        b_neg       = in_b_signed & rs2_data[XLEN-1];
        in_neg      = in_rem ? a_neg : (a_neg ^ b_neg);
        a_mag       = magnitude(rs1_data, a_neg);
        b_mag       = magnitude(rs2_data, b_neg);
        div_zero    = in_div & (rs2_data == '0);
        div_ovf     = in_div & ~funct3[0] & (rs1_data == INT_MIN) & (rs2_data == ALL_ONE);
        special     = div_zero | div_ovf;
        if (div_zero) begin
            special_res = in_rem ? rs1_data : ALL_ONE;
        end else begin
            special_res = in_rem ? '0 : INT_MIN;
        end
    end

    // One iteration: multiply keeps {high partial, remaining multiplier bits},
    // divide keeps {partial remainder, dividend/quotient bits}.
    always_comb begin
        mul_sum   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : '0);
        mul_nxt   = {mul_sum, acc_r[XLEN-1:1]};
        div_shift = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb_r};
        div_sub   = div_shift[XLEN-1:0] - opb_r;
        if (div_ge) begin
            div_nxt = {div_sub, acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_nxt = {div_shift[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
        acc_step  = op_r[2] ? div_nxt : mul_nxt;
    end

    assign accept = start & ~flush & ((state == S_IDLE) | (state == S_DONE));

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: begin
                stall = start;
                if (accept) state_nxt = special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (cnt == 5'd31) state_nxt = S_DONE;
            end
            S_DONE: begin
                stall        = start;
                result_valid = 1'b1;
                if (accept) begin
                    state_nxt = special ? S_DONE : S_BUSY;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
            end else if ((state == S_BUSY) && (cnt != 5'd31)) begin
                cnt <= cnt + 5'd1;
            end
            if (accept && special) begin
                result <= special_res;
            end else if (!flush && (state == S_BUSY) && (cnt == 5'd31)) begin
                result <= finalize(op_r, neg_r, acc_step);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= funct3;
            neg_r <= in_neg;
            opb_r <= in_div ? b_mag : a_mag;
            acc_r <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
        end else if (state == S_BUSY) begin
            acc_r <= acc_step;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed RV32M vectors, latency, stall,
// flush, back-to-back and asynchronous reset behaviour.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          vcyc;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          sp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [0:NVEC-1] = '{
        '{"mulh_m1_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
        '{"mulhu_ff_ff",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
        '{"mulhsu_m1_2",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0},
        '{"mulhsu_2_big", 3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0},
        '{"mul_lo",       3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0},
        '{"mul_m3_5",     3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0},
        '{"mulh_min_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
        '{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
        '{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
        '{"divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0},
        '{"remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0},
        '{"div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},
        '{"rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0},
        '{"divu_max_2",   3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0},
        '{"remu_max_10",  3'b111, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0},
        '{"divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1},
        '{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
        '{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
        '{"rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1'b1}
    };

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_cnt = 0;
    int   last_valid_cyc = -1;
    int   prev_valid_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            if (result_valid === 1'b1) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: result_valid=1 result=%h at cycle %0d, want no pulse",
                             result, cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_latency"}, cyc, e.vcyc);
                end
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input bit sp, input bit track);
        @(posedge clk);
        #1;
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{res: r, vcyc: cyc + (sp ? 0 : 32), name: name});
        start    = 1'b0;
        funct3   = ~f;
        rs1_data = 32'hA5A55A5A;
        rs2_data = 32'h00000003;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d results outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // MUL 7 x 6 with stall window measurement.
        @(posedge clk);
        #1;
        stall_cnt = 0;
        issue("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b1);
        chk("mul_busy_after_accept", 32'(busy), 32'd1);
        chk("mul_stall_after_accept", 32'(stall), 32'd1);
        wait_done("mul_7x6");
        @(negedge clk);
        chk("mul_stall_cycles", stall_cnt, 32'd33);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].sp, 1'b1);
            wait_done(vecs[i].name);
        end

        // Flush in the tenth BUSY cycle.
        issue("flush_op", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        chk("flush_result_kept", result, 32'd5);
        repeat (40) @(negedge clk);
        chk("flush_result_still_kept", result, 32'd5);
        issue("after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
        wait_done("after_flush");

        // Back-to-back: start held during the DONE cycle.
        issue("b2b_first", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) break;
        end
        start    = 1'b1;
        funct3   = 3'b101;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
        @(posedge clk);
        #1;
        sb.push_back('{res: 32'd14, vcyc: cyc + 32, name: "b2b_second"});
        start    = 1'b0;
        rs2_data = 32'd0;
        wait_done("b2b");
        chk("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd33);

        // Asynchronous reset in the middle of a BUSY operation.
        issue("rst_op", 3'b001, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue("after_reset", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
        wait_done("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
